// File: rtl/uart_cmd_ctrl_pkg.sv
// Shared types and constants for the UART command sequencer: FSM state
// encoding, default frame header, frame length and the checksum helper.
package uart_cmd_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_DHI   = 3'd2,
        ST_DLO   = 3'd3,
        ST_CHK   = 3'd4,
        ST_ISSUE = 3'd5
    } cmd_state_e;

    localparam logic [7:0] DEFAULT_HEADER = 8'hA5;
    localparam int         FRAME_LEN      = 5;

    // Modulo-256 sum; carries out of bit 7 are intentionally dropped.
    function automatic logic [7:0] frame_sum(input logic [7:0] a,
                                             input logic [7:0] h,
                                             input logic [7:0] l);
        return a + h + l;
    endfunction

endpackage

// File: rtl/uart_cmd_ctrl_if.sv
// Byte-in / command-out bundle between uart_receive, the sequencer and the
// register bank; the sequencer uses the slave side.
interface uart_cmd_ctrl_if;

    logic [7:0]  rx_data;
    logic        rx_new_data;
    // cmd_valid/cmd_ready: a command transfers on every posedge where both are
    // high; once raised, cmd_valid and its addr/data stay fixed until that
    // transfer (only reset may drop it); cmd_ready with cmd_valid low is ignored.
    logic        cmd_ready;
    logic        cmd_valid;
    logic [7:0]  cmd_addr;
    logic [15:0] cmd_data;
    logic        busy;
    logic        err_checksum;
    logic        err_timeout;
    logic        err_overrun;

    modport master (
        output rx_data, rx_new_data, cmd_ready,
        input  cmd_valid, cmd_addr, cmd_data, busy,
        input  err_checksum, err_timeout, err_overrun
    );

    modport slave (
        input  rx_data, rx_new_data, cmd_ready,
        output cmd_valid, cmd_addr, cmd_data, busy,
        output err_checksum, err_timeout, err_overrun
    );

endinterface

// File: rtl/uart_cmd_ctrl_edge_rise.sv
// Rising-edge detector: turns the receiver's new_data level into a
// single-cycle byte strobe.
module uart_cmd_ctrl_edge_rise (
    input  logic clk,
    input  logic rst,
    input  logic level_i,
    output logic rise_o
);

    logic nd_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            nd_q <= 1'b0;
        end else begin
            nd_q <= level_i;
        end
    end

    assign rise_o = level_i & ~nd_q;

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Assembles 5-byte framed commands (header, addr, hi, lo, checksum) from the
// UART byte stream and presents them on a valid/ready write port.
module uart_cmd_ctrl
    import uart_cmd_ctrl_pkg::*;
#(
    parameter logic [7:0] HEADER         = DEFAULT_HEADER,
    parameter int         TIMEOUT_CYCLES = 208320,
    parameter int         TMO_WIDTH      = 18
) (
    input  logic            clk,
    input  logic            rst,
    uart_cmd_ctrl_if.slave  bus,
    output cmd_state_e      dbg_state_o
);

    localparam logic [TMO_WIDTH-1:0] TMO_LAST = TMO_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [TMO_WIDTH-1:0] TMO_MAX  = {TMO_WIDTH{1'b1}};

    cmd_state_e           state_q;
    logic [TMO_WIDTH-1:0] tmo_q;
    logic [7:0]           addr_q, hi_q, lo_q;
    logic                 cmd_valid_q;
    logic [7:0]           cmd_addr_q;
    logic [15:0]          cmd_data_q;
    logic                 err_checksum_q, err_timeout_q, err_overrun_q;

    logic                 byte_stb;
    logic [7:0]           sum_d;
    logic                 tmo_hit_d;

    uart_cmd_ctrl_edge_rise u_edge (
        .clk     (clk),
        .rst     (rst),
        .level_i (bus.rx_new_data),
        .rise_o  (byte_stb)
    );

    assign sum_d     = frame_sum(addr_q, hi_q, lo_q);
    assign tmo_hit_d = (tmo_q == TMO_LAST);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= ST_IDLE;
            tmo_q          <= '0;
            addr_q         <= '0;
            hi_q           <= '0;
            lo_q           <= '0;
            cmd_valid_q    <= 1'b0;
            cmd_addr_q     <= '0;
            cmd_data_q     <= '0;
            err_checksum_q <= 1'b0;
            err_timeout_q  <= 1'b0;
            err_overrun_q  <= 1'b0;
        end else begin
            err_checksum_q <= 1'b0;
            err_timeout_q  <= 1'b0;
            err_overrun_q  <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    tmo_q <= '0;
                    if (byte_stb && bus.rx_data == HEADER) state_q <= ST_ADDR;
                end
                ST_ADDR, ST_DHI, ST_DLO, ST_CHK: begin
                    // A strobe on the terminal-count cycle wins over the timeout.
                    if (byte_stb) begin
                        tmo_q <= '0;
                        case (state_q)
                            ST_ADDR: begin addr_q <= bus.rx_data; state_q <= ST_DHI; end
                            ST_DHI:  begin hi_q   <= bus.rx_data; state_q <= ST_DLO; end
                            ST_DLO:  begin lo_q   <= bus.rx_data; state_q <= ST_CHK; end
                            default: begin
                                if (bus.rx_data == sum_d) begin
                                    state_q     <= ST_ISSUE;
                                    cmd_valid_q <= 1'b1;
                                    cmd_addr_q  <= addr_q;
                                    cmd_data_q  <= {hi_q, lo_q};
                                end else begin
                                    state_q        <= ST_IDLE;
                                    err_checksum_q <= 1'b1;
                                end
                            end
                        endcase
                    end else if (tmo_hit_d) begin
                        tmo_q         <= '0;
                        err_timeout_q <= 1'b1;
                        state_q       <= ST_IDLE;
                    end else if (tmo_q != TMO_MAX) begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                ST_ISSUE: begin
                    tmo_q <= '0;
                    // Bytes arriving while a command is pending are dropped, headers included.
                    if (byte_stb) err_overrun_q <= 1'b1;
                    if (bus.cmd_ready) begin
                        cmd_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.cmd_valid    = cmd_valid_q;
    assign bus.cmd_addr     = cmd_addr_q;
    assign bus.cmd_data     = cmd_data_q;
    assign bus.busy         = (state_q != ST_IDLE);
    assign bus.err_checksum = err_checksum_q;
    assign bus.err_timeout  = err_timeout_q;
    assign bus.err_overrun  = err_overrun_q;
    assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Self-checking bench for uart_cmd_ctrl: table of frames plus hand-written
// timeout, overrun, slow-byte and reset sequences, with a command scoreboard.
module tb_uart_cmd_ctrl;
    import uart_cmd_ctrl_pkg::*;

    localparam int         T   = 6000;
    localparam int         TW  = 13;
    localparam logic [7:0] HDR = 8'hA5;
    localparam int         NV  = 9;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    cmd_state_e dbg_state;

    always #5 clk = ~clk;

    uart_cmd_ctrl_if bus ();

    uart_cmd_ctrl #(
        .HEADER         (HDR),
        .TIMEOUT_CYCLES (T),
        .TMO_WIDTH      (TW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    typedef struct {
        logic [39:0] frame;
        logic        ok;
    } vec_t;

    vec_t        vecs [NV];
    logic [23:0] exp_q [$];
    logic [23:0] got_q [$];
    int          checks = 0;
    int          errors = 0;
    int          n_valid = 0, n_cksum = 0, n_tmo = 0, n_ovr = 0;
    int          n_long = 0, n_drop = 0;
    logic        p_valid = 1'b0, p_ready = 1'b0;
    logic        p_ck = 1'b0, p_tm = 1'b0, p_ov = 1'b0;

    // Monitor: collects handshakes and error pulses, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            if (bus.cmd_valid) n_valid++;
            if (bus.cmd_valid && bus.cmd_ready) got_q.push_back({bus.cmd_addr, bus.cmd_data});
            if (bus.err_checksum) n_cksum++;
            if (bus.err_timeout)  n_tmo++;
            if (bus.err_overrun)  n_ovr++;
            if ((bus.err_checksum && p_ck) || (bus.err_timeout && p_tm) || (bus.err_overrun && p_ov))
                n_long++;
            if (p_valid && !p_ready && !bus.cmd_valid) n_drop++;
            p_valid = bus.cmd_valid;
            p_ready = bus.cmd_ready;
            p_ck    = bus.err_checksum;
            p_tm    = bus.err_timeout;
            p_ov    = bus.err_overrun;
        end else begin
            p_valid = 1'b0;
            p_ready = 1'b0;
            p_ck    = 1'b0;
            p_tm    = 1'b0;
            p_ov    = 1'b0;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] model_sum(input logic [7:0] a, input logic [7:0] h,
                                             input logic [7:0] l);
        logic [9:0] s;
        s = {2'b00, a} + {2'b00, h} + {2'b00, l};
        return s[7:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drain(input string name);
        logic [23:0] g;
        logic [23:0] e;
        while (got_q.size() > 0) begin
            g = got_q.pop_front();
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL %s: unexpected command 0x%06h, none expected", name, g);
            end else begin
                e = exp_q.pop_front();
                check(name, g, e);
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int hold, input int gap);
        @(posedge clk); #1;
        bus.rx_data     = b;
        bus.rx_new_data = 1'b1;
        repeat (hold) @(posedge clk);
        #1 bus.rx_new_data = 1'b0;
        repeat (gap) @(posedge clk);
    endtask

    task automatic send_frame(input logic [39:0] f, input int hold, input int gap);
        for (int j = FRAME_LEN - 1; j >= 0; j--) send_byte(f[j*8 +: 8], hold, gap);
    endtask

    task automatic check_idle_outputs(input string name);
        check({name, " state"}, 32'(dbg_state), 32'(ST_IDLE));
        check({name, " busy"},  bus.busy, 0);
        check({name, " valid"}, bus.cmd_valid, 0);
        check({name, " addr"},  bus.cmd_addr, 0);
        check({name, " data"},  bus.cmd_data, 0);
        check({name, " errs"},  {bus.err_checksum, bus.err_timeout, bus.err_overrun}, 0);
    endtask

    initial begin
        logic [7:0] a, h, l, c;
        int base_v, base_c, base_t, base_o, k;
        logic seen;

        bus.rx_data     = 8'h00;
        bus.rx_new_data = 1'b0;
        bus.cmd_ready   = 1'b1;
        rst             = 1'b0;

        vecs[0] = '{frame: 40'hA5_10_12_34_56, ok: 1'b1};
        vecs[1] = '{frame: 40'hA5_10_12_34_57, ok: 1'b0};
        vecs[2] = '{frame: 40'hA5_FF_FF_FF_FD, ok: 1'b1};
        vecs[3] = '{frame: 40'hA5_00_00_00_00, ok: 1'b1};
        vecs[4] = '{frame: 40'hA5_80_80_80_81, ok: 1'b0};
        vecs[5] = '{frame: 40'hA5_A5_A5_A5_EF, ok: 1'b1};
        vecs[6] = '{frame: 40'hA5_01_02_03_00, ok: 1'b0};
        for (int i = 7; i < NV; i++) begin
            a = 8'($urandom_range(0, 255));
            h = 8'($urandom_range(0, 255));
            l = 8'($urandom_range(0, 255));
            c = model_sum(a, h, l);
            if (i == 8) c = c ^ 8'h01;
            vecs[i] = '{frame: {HDR, a, h, l, c}, ok: (i == 7)};
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(posedge clk);

        for (int i = 0; i < NV; i++) begin
            {a, h, l, c} = vecs[i].frame[31:0];
            base_v = n_valid;
            base_c = n_cksum;
            if (vecs[i].ok) exp_q.push_back({a, h, l});
            for (int j = FRAME_LEN - 1; j >= 1; j--) send_byte(vecs[i].frame[j*8 +: 8], 1, 2);
            @(posedge clk); #1;
            bus.rx_data     = c;
            bus.rx_new_data = 1'b1;
            @(negedge clk);
            check("vec valid before chk edge", bus.cmd_valid, 0);
            @(negedge clk);
            check("vec valid after chk", bus.cmd_valid, vecs[i].ok);
            check("vec err_checksum", bus.err_checksum, !vecs[i].ok);
            check("vec busy after chk", bus.busy, vecs[i].ok);
            @(posedge clk); #1 bus.rx_new_data = 1'b0;
            repeat (3) @(posedge clk);
            @(negedge clk);
            check("vec valid cycles", n_valid - base_v, vecs[i].ok);
            check("vec checksum pulses", n_cksum - base_c, !vecs[i].ok);
            check("vec idle", bus.busy, 0);
            drain("vec cmd");
        end

        // Stall after the address byte until the timeout fires.
        base_t = n_tmo;
        send_byte(HDR, 1, 2);
        @(posedge clk); #1;
        bus.rx_data     = 8'h10;
        bus.rx_new_data = 1'b1;
        seen = 1'b0;
        k    = 0;
        while (!seen && k < 2 * T) begin
            @(negedge clk);
            k++;
            if (k == 2) bus.rx_new_data = 1'b0;
            if (bus.err_timeout) seen = 1'b1;
        end
        check("timeout seen", seen, 1);
        check("timeout latency", k, T + 2);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("timeout pulses", n_tmo - base_t, 1);
        check("timeout idle", 32'(dbg_state), 32'(ST_IDLE));
        base_v = n_valid;
        exp_q.push_back(24'h10_1234);
        send_frame(40'hA5_10_12_34_56, 1, 2);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("post-timeout cmd", n_valid - base_v, 1);
        drain("post-timeout cmd");

        // Byte lands exactly on the terminal-count cycle: byte wins.
        base_t = n_tmo;
        base_v = n_valid;
        exp_q.push_back(24'h41_5263);
        send_byte(HDR, 1, 2);
        @(posedge clk); #1;
        bus.rx_data     = 8'h41;
        bus.rx_new_data = 1'b1;
        @(posedge clk); #1 bus.rx_new_data = 1'b0;
        repeat (T - 1) @(posedge clk);
        #1;
        bus.rx_data     = 8'h52;
        bus.rx_new_data = 1'b1;
        @(posedge clk); #1 bus.rx_new_data = 1'b0;
        repeat (2) @(posedge clk);
        send_byte(8'h63, 1, 2);
        send_byte(8'hF6, 1, 2);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("tc race no timeout", n_tmo - base_t, 0);
        check("tc race cmd", n_valid - base_v, 1);
        drain("tc race cmd");

        // Overrun while the command is held by cmd_ready=0.
        bus.cmd_ready = 1'b0;
        base_o = n_ovr;
        exp_q.push_back(24'h22_3344);
        send_frame(40'hA5_22_33_44_99, 1, 2);
        @(negedge clk);
        check("hold valid", bus.cmd_valid, 1);
        check("hold addr", bus.cmd_addr, 8'h22);
        check("hold data", bus.cmd_data, 16'h3344);
        send_byte(8'h77, 1, 3);
        @(negedge clk);
        check("overrun pulses", n_ovr - base_o, 1);
        check("overrun valid", bus.cmd_valid, 1);
        check("overrun addr", bus.cmd_addr, 8'h22);
        check("overrun data", bus.cmd_data, 16'h3344);
        @(posedge clk); #1;
        bus.cmd_ready   = 1'b1;
        bus.rx_data     = HDR;
        bus.rx_new_data = 1'b1;
        @(posedge clk); #1 bus.rx_new_data = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("ready+byte overrun", n_ovr - base_o, 2);
        check("ready+byte accepted", bus.cmd_valid, 0);
        check("header in issue dropped", bus.busy, 0);
        drain("overrun cmd");
        base_v = n_valid;
        send_byte(8'h10, 1, 2);
        send_byte(8'h12, 1, 2);
        send_byte(8'h34, 1, 2);
        send_byte(8'h56, 1, 2);
        @(negedge clk);
        check("headerless ignored", n_valid - base_v, 0);
        check("headerless idle", bus.busy, 0);

        // Garbage then a frame, every byte held high for 5000 cycles.
        base_v = n_valid;
        base_c = n_cksum;
        base_t = n_tmo;
        exp_q.push_back(24'h10_1234);
        send_frame(40'h00_FF_3C_00_00, 5000, 2);
        check("garbage idle", bus.busy, 0);
        send_frame(40'hA5_10_12_34_56, 5000, 2);
        @(negedge clk);
        check("slow bytes one cmd", n_valid - base_v, 1);
        check("slow bytes no errs", (n_cksum - base_c) + (n_tmo - base_t), 0);
        drain("slow cmd");

        // Reset in DLO, then a clean frame.
        send_byte(HDR, 1, 2);
        send_byte(8'h10, 1, 2);
        send_byte(8'h12, 1, 2);
        @(negedge clk);
        check("in DLO", 32'(dbg_state), 32'(ST_DLO));
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset in DLO");
        @(posedge clk); #1 rst = 1'b1;
        base_v = n_valid;
        exp_q.push_back(24'h10_1234);
        send_frame(40'hA5_10_12_34_56, 1, 2);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("post-reset cmd", n_valid - base_v, 1);
        drain("post-reset cmd");

        // Reset while a command is pending: it is lost silently.
        bus.cmd_ready = 1'b0;
        base_o = n_ovr;
        send_frame(40'hA5_01_02_03_06, 1, 2);
        @(negedge clk);
        check("pending before reset", bus.cmd_valid, 1);
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset in ISSUE");
        @(posedge clk); #1 rst = 1'b1;
        bus.cmd_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset issue no overrun", n_ovr - base_o, 0);
        drain("reset issue");

        drain("final");
        check("scoreboard empty", exp_q.size(), 0);
        check("single-cycle pulses", n_long, 0);
        check("valid held until ready", n_drop, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_cmd_ctrl.md
# uart_cmd_ctrl

Command sequencer behind `uart_receive`. It takes the receiver's byte stream (`data`/`new_data`) and assembles 5-byte framed commands: header, address, data high, data low, checksum. Valid commands go out on a valid/ready write port toward the register bank. Bad frames are dropped and flagged, and the block recovers from stalled or partial frames with an inter-byte timeout.

## Interface
Parameters:
- `HEADER`, 8'hA5, frame start byte.
- `TIMEOUT_CYCLES`, 208320, max clk cycles between bytes inside a frame (20 bit periods at 10416 clk/bit).
- `TMO_WIDTH`, 18, timeout counter width; must hold `TIMEOUT_CYCLES`.

Ports:
- `clk` input 1: system clock; all logic on posedge.
- `rst` input 1: synchronous, active-low reset.
- `rx_data` input 8: byte from `uart_receive.data`.
- `rx_new_data` input 1: `uart_receive.new_data`. This is a level that stays high for the rest of the stop bit.
- `cmd_ready` input 1: consumer accepts the command.
- `cmd_valid` output 1: command available.
- `cmd_addr` output 8: command address.
- `cmd_data` output 16: command data, {hi, lo}.
- `busy` output 1: high whenever state is not IDLE.
- `err_checksum` output 1: one-cycle pulse on checksum mismatch.
- `err_timeout` output 1: one-cycle pulse on inter-byte timeout.
- `err_overrun` output 1: one-cycle pulse when a byte arrives while a command is pending.

## Operation
- Byte strobe `byte_stb` = rising edge of `rx_new_data`, detected with a 1-flop history register (`nd_q`). Only strobes are acted on; the level is otherwise ignored.
- States and transitions:
  - IDLE: on `byte_stb` with `rx_data == HEADER`, go to ADDR. Any other byte is discarded silently.
  - ADDR: on `byte_stb`, latch `addr` and go to DHI.
  - DHI: on `byte_stb`, latch `hi` and go to DLO.
  - DLO: on `byte_stb`, latch `lo` and go to CHK.
  - CHK: on `byte_stb`, compare `rx_data` with `(addr + hi + lo) mod 256`. The sum is 8 bits and carries are discarded.
    - Match: go to ISSUE.
    - Mismatch: pulse `err_checksum` and go to IDLE.
  - ISSUE: `cmd_valid=1`. On `cmd_valid && cmd_ready`, go to IDLE and drop `cmd_valid` the next cycle. A `byte_stb` in ISSUE pulses `err_overrun` and the byte is discarded. A header arriving during ISSUE is NOT captured.
- `cmd_addr` and `cmd_data` update only on the ISSUE entry edge and hold stable while `cmd_valid` is high.
- Timeout counter:
  - Cleared on every `byte_stb` and in IDLE/ISSUE.
  - Increments each cycle in ADDR/DHI/DLO/CHK, saturating.
  - When it reaches `TIMEOUT_CYCLES - 1` without a strobe: pulse `err_timeout` and go to IDLE.
- Simultaneous events:
  - `byte_stb` and timeout terminal count in the same cycle: the byte wins and no timeout fires.
  - `cmd_ready` and `byte_stb` in the same ISSUE cycle: the command is accepted and `err_overrun` still pulses.

## Timing
- Reset values: `cmd_valid=0`, `cmd_addr=0`, `cmd_data=0`, `busy=0`, all `err_*=0`, state IDLE, counter 0, `nd_q=0`.
- Reset mid-frame or mid-ISSUE abandons everything next cycle. A pending command is lost without an error pulse.
- Latencies:
  - `rx_new_data` rise at cycle n gives `byte_stb` combinationally at cycle n; the state register updates at the n+1 edge.
  - `cmd_valid` rises 1 cycle after the CHK strobe.
  - `err_*` pulse exactly 1 cycle, registered, in the cycle after the triggering event.
- Handshake: `cmd_valid` never deasserts without `cmd_ready` (except on reset). `cmd_ready` high while `cmd_valid` is low has no effect.
- Back-to-back frames: a header strobe that arrives after the ISSUE handshake is accepted normally.

## Structure
- Shared include `uart_cmd_defines.v`:
  - state encodings `CMD_IDLE`, `CMD_ADDR`, `CMD_DHI`, `CMD_DLO`, `CMD_CHK`, `CMD_ISSUE` (3 bits);
  - default `HEADER`;
  - frame length constant.
- One sub-module is natural: `edge_rise` (flop plus AND) producing `byte_stb`. The timeout counter stays inline.
- Next-state logic is combinational (`always @(*)`) with registered outputs.

## Test plan
- Frame A5 10 12 34 56 (sum 0x56) with `cmd_ready` held 1 → one `cmd_valid` cycle, `cmd_addr=8'h10`, `cmd_data=16'h1234`, no errors.
- Frame A5 10 12 34 57 → `err_checksum` pulses once, no `cmd_valid`, `busy` low the next cycle.
- A5 10, then silence for `TIMEOUT_CYCLES` → `err_timeout` pulses once and returns to IDLE. A following full valid frame is issued correctly.
- Valid frame with `cmd_ready=0`, then a byte 0x77 arrives → `err_overrun` pulses, and `cmd_addr`/`cmd_data` stay unchanged until `cmd_ready` rises.
- Garbage 00 FF 3C before a valid frame, and `rx_new_data` held high for 5000 cycles per byte → garbage is ignored, each byte counts once, and the command is issued once.
- `rst=0` asserted during DLO → all outputs zero next cycle. A subsequent valid frame is issued normally.
